// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helper and the control-state encoding used by
// the iterative column-mix datapath.
package aes_pkg;

  localparam int BYTE   = 8;
  localparam int DWORD  = 32;
  localparam int LENGTH = 128;

  localparam logic [BYTE-1:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
    return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_set_column.sv
// Combinational InvMixColumns core for one 32-bit column; row 0 lives in
// bits [31:24], row 3 in bits [7:0].
module inv_set_column
  import aes_pkg::*;
(
  input  logic [DWORD-1:0] data_i,
  output logic [DWORD-1:0] data_o
);

  // Constant multiply by a 4-bit coefficient k, assembled from the x, x^2 and
  // x^3 multiples of a, so the four inverse coefficients share one xtime chain.
  function automatic logic [BYTE-1:0] gmul_k(input logic [BYTE-1:0] a,
                                              input logic [3:0]      k);
    logic [BYTE-1:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  logic [BYTE-1:0] a0, a1, a2, a3;
  logic [BYTE-1:0] r0, r1, r2, r3;

  assign {a0, a1, a2, a3} = data_i;

  assign r0 = gmul_k(a0, 4'hE) ^ gmul_k(a1, 4'hB) ^ gmul_k(a2, 4'hD) ^ gmul_k(a3, 4'h9);
  assign r1 = gmul_k(a0, 4'h9) ^ gmul_k(a1, 4'hE) ^ gmul_k(a2, 4'hB) ^ gmul_k(a3, 4'hD);
  assign r2 = gmul_k(a0, 4'hD) ^ gmul_k(a1, 4'h9) ^ gmul_k(a2, 4'hE) ^ gmul_k(a3, 4'hB);
  assign r3 = gmul_k(a0, 4'hB) ^ gmul_k(a1, 4'hD) ^ gmul_k(a2, 4'h9) ^ gmul_k(a3, 4'hE);

  assign data_o = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: accepts a 128-bit state, rewrites one column per
// cycle through a shared core, then offers the result on a valid/ready port.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data
);

  state_e            state_q, state_d;
  logic [1:0]        col_cnt_q, col_cnt_d;
  logic [LENGTH-1:0] work_q, work_d;
  logic [LENGTH-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DWORD-1:0]  core_in, core_out;

  assign core_in = work_q[{col_cnt_q, 5'd0} +: DWORD];

  inv_set_column u_core (
    .data_i (core_in),
    .data_o (core_out)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          work_d    = in_data;
          col_cnt_d = 2'd0;
          state_d   = CALC;
        end
      end
      CALC: begin
        work_d[{col_cnt_q, 5'd0} +: DWORD] = core_out;
        col_cnt_d = col_cnt_q + 2'd1;
        // The last column goes straight into the output register, bypassing work_q.
        if (col_cnt_q == 2'd3) begin
          out_data_d  = {core_out, work_q[LENGTH-DWORD-1:0]};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next-state value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: a matrix-level GF(2^8) model
// and a cycle-level handshake scoreboard are compared against the DUT.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [127:0] data;
    int           edge_no;
  } exp_t;

  exp_t sb[$];
  logic armed     = 1'b0;
  logic zero_exp  = 1'b0;
  logic rand_ready = 1'b0;
  logic exp_ready, exp_valid;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant column mix: row i, input row j uses coefficient base[(j-i) mod 4].
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [7:0] b0,
                                       input logic [7:0] b1, input logic [7:0] b2,
                                       input logic [7:0] b3);
    logic [7:0]   base[4];
    logic [7:0]   a[4];
    logic [7:0]   r;
    logic [127:0] o;
    base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[32*c + 24 - 8*j +: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r ^= gmul(base[(j - i) & 3], a[j]);
        o[32*c + 24 - 8*i +: 8] = r;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return mix(s, 8'h0E, 8'h0B, 8'h0D, 8'h09);
  endfunction

  function automatic logic [127:0] fwd_model(input logic [127:0] s);
    return mix(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  // Compare process: check outputs against the model, then apply the events
  // the upcoming rising edge will see.
  always @(negedge clk) begin
    exp_ready = !rst && (sb.size() == 0);
    exp_valid = (sb.size() > 0) && (cyc >= sb[0].edge_no + 4);
    if (armed) begin
      check("in_ready", {127'b0, in_ready}, {127'b0, exp_ready});
      check("out_valid", {127'b0, out_valid}, {127'b0, exp_valid});
      if (exp_valid) check("out_data", out_data, sb[0].data);
      else if (zero_exp) check("out_data_after_reset", out_data, '0);
    end
    if (exp_valid) zero_exp = 1'b0;
    if (rst) begin
      sb.delete();
      zero_exp = 1'b1;
      armed    = 1'b1;
    end else begin
      if (exp_valid && out_ready) void'(sb.pop_front());
      if (exp_ready && in_valid) sb.push_back('{inv_model(in_data), cyc + 1});
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout at cycle %0d: in_ready never rose", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || !in_ready) && n < 300);
    if (sb.size() != 0 || !in_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout at cycle %0d: block did not return to idle", cyc);
    end
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] V1_IN  = 128'hd5d5d7d6_01010101_9fdc589d_8e4da1bc;
  localparam logic [127:0] V1_OUT = 128'hd4d4d4d5_01010101_f20a225c_db135345;
  localparam logic [127:0] V2     = {4{32'hc6c6c6c6}};
  localparam logic [127:0] V3_IN  = {32'h0, 32'h4d7ebdf8, 64'h0};
  localparam logic [127:0] V3_OUT = {32'h0, 32'h2d26314c, 64'h0};

  initial begin
    logic [127:0] s, e;
    int n;

    check("model_vec1", inv_model(V1_IN), V1_OUT);
    check("model_c6", inv_model(V2), V2);
    check("model_w2", inv_model(V3_IN), V3_OUT);
    check("model_fwd_vec1", fwd_model(V1_OUT), V1_IN);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors with out_ready held high throughout.
    out_ready = 1'b1;
    send(V1_IN);  in_valid = 1'b0; wait_idle();
    send(V2);     in_valid = 1'b0; wait_idle();
    send(V3_IN);  in_valid = 1'b0; wait_idle();

    // Backpressure: hold the result for 10 cycles while poking in_valid.
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom});
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL backpressure_wait at cycle %0d: out_valid never rose", cyc);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_idle();

    // Reset on the second CALC cycle, then a clean state.
    out_ready = 1'b1;
    send(V1_IN);
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(V3_IN); in_valid = 1'b0; wait_idle();

    // Back-to-back with in_valid held high and DONE overlapping in_valid.
    send(V2);
    send(V1_IN);
    send({$urandom, $urandom, $urandom, $urandom});
    in_valid = 1'b0;
    wait_idle();

    // Round trip through the forward mix with random gaps and backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      e = fwd_model(s);
      check("model_round_trip", inv_model(e), s);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(e);
      in_valid = 1'b0;
    end
    @(posedge clk); #2;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
